// File: rtl/actuator_guard.sv
// ---------------------------------------------------------------------------
// actuator_guard
//
// Purpose:
//   Protects a heater and a fan driven by a temperature comparator.
//   - Only one actuator can be on at a time.
//   - Once an actuator turns on, it stays on for a minimum time.
//   - A both-off gap is enforced between any turn-off and the next turn-on.
//   The block is a four-state FSM (IDLE, HEAT, COOL, DEAD). One dwell
//   counter is shared by all states and restarts from zero on every state
//   change.
//
// Parameters:
//   DEAD_CYCLES    both-off gap in cycles after any turn-off (1..65535)
//   MIN_ON_CYCLES  minimum on-time of an actuator in cycles (1..65535)
//
// Ports:
//   clk           single clock, rising-edge
//   rst           asynchronous active-high reset
//   heater_req    heat request from the comparator
//   fan_req       cool request from the comparator
//   enable        system enable; low forces both actuators off
//   heater_out    heater drive (high exactly while in HEAT)
//   fan_out       fan drive (high exactly while in COOL)
//   state         current FSM state: 0 IDLE, 1 HEAT, 2 COOL, 3 DEAD
//   conflict      registered flag: both requests were high on the last edge
//   switch_count  saturating count of entries into HEAT or COOL
// ---------------------------------------------------------------------------
module actuator_guard #(
  parameter int DEAD_CYCLES   = 100,
  parameter int MIN_ON_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        heater_req,
  input  logic        fan_req,
  input  logic        enable,
  output logic        heater_out,
  output logic        fan_out,
  output logic [1:0]  state,
  output logic        conflict,
  output logic [15:0] switch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    DEAD = 2'd3
  } state_t;

  // Terminal counts for the dwell counter.
  // The counter runs 0..N-1, so N-1 marks the last cycle of a dwell.
  localparam logic [15:0] MIN_ON_LAST = 16'(MIN_ON_CYCLES - 1);
  localparam logic [15:0] DEAD_LAST   = 16'(DEAD_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        conflict_q;
  logic        conflict_d;
  logic [15:0] switch_count_q;
  logic [15:0] switch_count_d;

  logic        hreq;
  logic        freq;
  logic        min_on_done;
  logic        dead_done;
  logic        entering_on;

  // Contradictory requests (both high) are treated as no request at all.
  // The comparator should never produce them, so refusing to act is the
  // safe choice.
  assign hreq = heater_req & ~fan_req & enable;
  assign freq = fan_req & ~heater_req & enable;

  assign min_on_done = (cnt_q == MIN_ON_LAST);
  assign dead_done   = (cnt_q == DEAD_LAST);

  // Next-state logic.
  // HEAT and COOL never go directly to each other. They always leave through
  // DEAD, which guarantees the both-off gap. Dropping enable skips the
  // minimum on-time but still goes through DEAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hreq) begin
          state_d = HEAT;
        end else if (freq) begin
          state_d = COOL;
        end
      end

      HEAT: begin
        if (!min_on_done) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (!enable) begin
          state_d = DEAD;
        end else if (!hreq && min_on_done) begin
          state_d = DEAD;
        end
      end

      COOL: begin
        if (!min_on_done) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (!enable) begin
          state_d = DEAD;
        end else if (!freq && min_on_done) begin
          state_d = DEAD;
        end
      end

      DEAD: begin
        cnt_d = cnt_q + 16'd1;
        if (dead_done) begin
          if (hreq) begin
            state_d = HEAT;
          end else if (freq) begin
            state_d = COOL;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Every state change starts the new dwell from zero.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Bookkeeping: conflict flag and switch counter.
  // The conflict flag looks at the raw requests and ignores enable, so it
  // reports comparator faults even while the system is disabled.
  // The switch counter sticks at all-ones rather than wrapping back to a
  // small value.
  always_comb begin
    conflict_d     = heater_req & fan_req;
    entering_on    = ((state_d == HEAT) || (state_d == COOL)) && (state_d != state_q);
    switch_count_d = switch_count_q;
    if (entering_on && (switch_count_q != 16'hFFFF)) begin
      switch_count_d = switch_count_q + 16'd1;
    end
  end

  // State registers.
  // Reset goes straight to IDLE with no DEAD interval. Because the outputs
  // are decoded from state, the actuators drop as soon as reset rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      conflict_q     <= 1'b0;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      conflict_q     <= conflict_d;
      switch_count_q <= switch_count_d;
    end
  end

  // Drives come straight from the state register. They are mutually
  // exclusive by construction, and never depend on the live request inputs.
  assign heater_out   = (state_q == HEAT);
  assign fan_out      = (state_q == COOL);
  assign state        = state_q;
  assign conflict     = conflict_q;
  assign switch_count = switch_count_q;

endmodule

// File: doc/actuator_guard.md
ACTUATOR_GUARD -- requirements
Module: actuator_guard

Interface
REQ-001 Parameter: DEAD_CYCLES, default 100, both-off gap in cycles enforced between any actuator turn-off and the next turn-on; legal 1..65535.
REQ-002 Parameter: MIN_ON_CYCLES, default 1000, minimum cycles an actuator output stays high once asserted (except on enable drop or reset); legal 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 heater_req  input  1  heat request from the combinational temperature comparator.
REQ-006 fan_req  input  1  cool request from the same comparator.
REQ-007 enable  input  1  system enable; low forces both actuators off.
REQ-008 heater_out  output  1  registered heater drive.
REQ-009 fan_out  output  1  registered fan drive.
REQ-010 state  output  2  current FSM state: 0 IDLE, 1 HEAT, 2 COOL, 3 DEAD.
REQ-011 conflict  output  1  registered one-cycle flag: both requests sampled high.
REQ-012 switch_count  output  16  number of entries into HEAT or COOL since reset.

Function
REQ-013 The block SHALL be a 4-state FSM (IDLE, HEAT, COOL, DEAD) with a single 16-bit dwell counter cnt, cleared to 0 on every state entry.
REQ-014 heater_out SHALL equal (state==HEAT) and fan_out SHALL equal (state==COOL), both decoded from the state register; heater_out and fan_out SHALL never be high together.
REQ-015 Effective requests: hreq = heater_req & ~fan_req & enable; freq = fan_req & ~heater_req & enable; both requests high SHALL count as no request.
REQ-016 IDLE: hreq -> HEAT; freq -> COOL; else remain IDLE; so an output rises on the edge that samples the request (1-cycle latency).
REQ-017 HEAT: cnt increments each cycle, saturating at MIN_ON_CYCLES-1; enable low -> DEAD immediately regardless of cnt; else if ~hreq and cnt==MIN_ON_CYCLES-1 -> DEAD; else remain.
REQ-018 COOL: identical to HEAT with freq in place of hreq.
REQ-019 Consequence: absent enable drop, heater_out/fan_out SHALL be high for at least MIN_ON_CYCLES consecutive cycles.
REQ-020 DEAD: both outputs 0; cnt increments; when cnt==DEAD_CYCLES-1: hreq -> HEAT, freq -> COOL, else -> IDLE; so both outputs are low for exactly DEAD_CYCLES cycles between any fall and the next rise.
REQ-021 A reversal (HEAT to COOL or COOL to HEAT) SHALL always pass through DEAD; there is no direct HEAT<->COOL transition.
REQ-022 conflict SHALL be registered as (heater_req & fan_req) each cycle, independent of state and enable.
REQ-023 switch_count SHALL increment by 1 on each transition into HEAT or COOL, saturating at 16'hFFFF (no wrap).
REQ-024 Parameters at value 1: MIN_ON_CYCLES=1 permits leaving HEAT/COOL one cycle after entry; DEAD_CYCLES=1 gives a one-cycle gap.

Reset
REQ-025 While rst is high, asynchronously: state=IDLE, cnt=0, heater_out=0, fan_out=0, conflict=0, switch_count=0.
REQ-026 Reset asserted mid-HEAT/COOL/DEAD SHALL drop outputs immediately without a DEAD interval; after release, the first edge sampling a valid request enters HEAT/COOL directly.

Verification (DEAD_CYCLES=4, MIN_ON_CYCLES=8)
REQ-027 Reset: assert rst with heater_req=1 -> heater_out=0, fan_out=0, state=0, switch_count=0 throughout; release -> heater_out=1 after first edge, switch_count=1.
REQ-028 Min-on: enable=1, heater_req high for 2 cycles then low -> heater_out high exactly 8 cycles, then state=3 for 4 cycles, then state=0.
REQ-029 Reversal: heater_req held 20 cycles then fan_req high, heater_req low -> heater_out falls, fan_out rises exactly 4 cycles later, no overlap cycle, switch_count=2.
REQ-030 Conflict: heater_req=fan_req=1 for 5 cycles from IDLE -> outputs stay 0, state=0, conflict high 5 cycles starting one edge later.
REQ-031 Enable drop: enable low at cycle 3 of HEAT -> heater_out=0 next edge, DEAD 4 cycles, then IDLE held while enable=0 despite heater_req=1.
REQ-032 Mid-reset and saturation: rst pulsed during COOL -> fan_out=0 immediately; force 65536 entries -> switch_count holds 16'hFFFF.
